// File: rtl/ram_dp_bitmask_arbiter_pkg.sv
// ram_arb_pkg: shared types and constants for the dual-port RAM arbiter.
//   state_e      - top-level FSM state (sweep in progress / normal operation)
//   PORT_A/B     - encoding of the registered per-requester port select
//   idx_width()  - width of a requester index, never less than one bit
package ram_arb_pkg;

    typedef enum logic [0:0] {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_dp_bitmask_arbiter_rr_pick.sv
// rr_pick: round-robin pick of the first eligible requester, searching upward
// from a start index with wrap-around.
//   eligible - requesters that may be picked this cycle
//   start    - index the search begins at (must be below NUM_REQ)
//   grant    - one-hot of the picked requester, all zero if none
//   found    - a requester was picked
//   index    - binary index of the picked requester (0 when none)
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_WIDTH = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   eligible,
    input  logic [IDX_WIDTH-1:0] start,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] index
);

    int unsigned cand;

    always_comb begin
        grant = '0;
        found = 1'b0;
        index = '0;
        cand  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(start) + k) % NUM_REQ;
            if (!found && eligible[IDX_WIDTH'(cand)]) begin
                found                    = 1'b1;
                grant[IDX_WIDTH'(cand)]  = 1'b1;
                index                    = IDX_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/ram_dp_bitmask_arbiter.sv
// ram_dp_bitmask_arbiter: shares one dual-port bit-masked RAM between
// NUM_REQ requesters, granting up to two requests per cycle.
//   clock, reset          - clock (rising edge), asynchronous active-high reset
//   clear, init_busy      - start a zeroing sweep / sweep in progress
//   req_valid/ready       - per-requester handshake; transfer on valid & ready
//   req_wen/bwen/addr/din - per-requester command fields (packed, slice i)
//   rsp_valid/rsp_rdata   - per-requester read response, one cycle after grant
//   ram_*                 - RAM macro pins; this block is their only driver
// After reset (and on clear) every RAM word is zeroed two entries per cycle
// before any request is accepted.
module ram_dp_bitmask_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned NUM_REQ    = 4,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    output logic                          init_busy,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_wen,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_bwen,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata,
    output logic                          ram_cen,
    output logic                          ram_wen_a,
    output logic                          ram_wen_b,
    output logic [DATA_WIDTH-1:0]         ram_bwen_a,
    output logic [DATA_WIDTH-1:0]         ram_bwen_b,
    output logic [ADDR_WIDTH-1:0]         ram_addr_a,
    output logic [ADDR_WIDTH-1:0]         ram_addr_b,
    output logic [DATA_WIDTH-1:0]         ram_din_a,
    output logic [DATA_WIDTH-1:0]         ram_din_b,
    input  logic [DATA_WIDTH-1:0]         ram_dout_a,
    input  logic [DATA_WIDTH-1:0]         ram_dout_b
);

    localparam int unsigned IDX_WIDTH = idx_width(NUM_REQ);
    localparam bit          DEPTH_ODD = (DEPTH % 2) == 1;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  clr_ptr_q, clr_ptr_d;
    logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]     port_sel_q, port_sel_d;

    logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]  din_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  bwen_arr [NUM_REQ];

    logic [NUM_REQ-1:0]     eligible_a, eligible_b, conflict;
    logic [NUM_REQ-1:0]     grant_a, grant_b;
    logic                   found_a, found_b;
    logic [IDX_WIDTH-1:0]   idx_a, idx_b, after_a, after_b;
    logic                   sweep_last;

    // ---------------------------------------------------------------------
    // Request unpacking, hazard detection and response data steering
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign din_arr[i]  = req_din[i*DATA_WIDTH +: DATA_WIDTH];
        assign bwen_arr[i] = req_bwen[i*DATA_WIDTH +: DATA_WIDTH];

        // Same address as port A's pick is only safe when both sides read.
        assign conflict[i] = (addr_arr[i] == addr_arr[idx_a]) &&
                             (req_wen[i] || req_wen[idx_a]);

        // Port select is registered with the grant so it lines up with the
        // RAM's registered read data one cycle later.
        assign rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] =
            (port_sel_q[i] == PORT_B) ? ram_dout_b : ram_dout_a;
    end

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    // Grants are only possible in RUN and never in a cycle that starts a clear.
    assign eligible_a = ((state_q == ST_RUN) && !clear) ? req_valid : '0;

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick_a (
        .eligible (eligible_a),
        .start    (rr_ptr_q),
        .grant    (grant_a),
        .found    (found_a),
        .index    (idx_a)
    );

    assign after_a = (idx_a == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : idx_a + 1'b1;
    assign after_b = (idx_b == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : idx_b + 1'b1;

    assign eligible_b = found_a ? (eligible_a & ~grant_a & ~conflict) : '0;

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick_b (
        .eligible (eligible_b),
        .start    (after_a),
        .grant    (grant_b),
        .found    (found_b),
        .index    (idx_b)
    );

    assign req_ready   = grant_a | grant_b;
    assign rsp_valid_d = req_ready & ~req_wen;

    always_comb begin
        port_sel_d = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            port_sel_d[IDX_WIDTH'(i)] = grant_b[IDX_WIDTH'(i)] ? PORT_B : PORT_A;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------------
    assign sweep_last = (32'(clr_ptr_q) + 32'd2) >= DEPTH;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            ST_INIT: begin
                if (clear) begin
                    clr_ptr_d = '0;
                end else if (sweep_last) begin
                    state_d   = ST_RUN;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(2);
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_d   = ST_INIT;
                    clr_ptr_d = '0;
                end else if (found_b) begin
                    rr_ptr_d = after_b;
                end else if (found_a) begin
                    rr_ptr_d = after_a;
                end
            end
            default: begin
                state_d   = ST_INIT;
                clr_ptr_d = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // RAM pins
    // ---------------------------------------------------------------------
    always_comb begin
        ram_cen    = 1'b0;
        ram_wen_a  = 1'b0;
        ram_wen_b  = 1'b0;
        ram_bwen_a = '0;
        ram_bwen_b = '0;
        ram_addr_a = '0;
        ram_addr_b = '0;
        ram_din_a  = '0;
        ram_din_b  = '0;
        if (state_q == ST_INIT) begin
            ram_cen    = 1'b1;
            ram_wen_a  = 1'b1;
            // Odd depth: the final pair has no second entry, so B just reads.
            ram_wen_b  = !(DEPTH_ODD && sweep_last);
            ram_bwen_a = '1;
            ram_bwen_b = '1;
            ram_addr_a = clr_ptr_q;
            ram_addr_b = clr_ptr_q + 1'b1;
        end else begin
            ram_cen = found_a;
            if (found_a) begin
                ram_wen_a  = req_wen[idx_a];
                ram_bwen_a = bwen_arr[idx_a];
                ram_addr_a = addr_arr[idx_a];
                ram_din_a  = din_arr[idx_a];
            end
            if (found_b) begin
                ram_wen_b  = req_wen[idx_b];
                ram_bwen_b = bwen_arr[idx_b];
                ram_addr_b = addr_arr[idx_b];
                ram_din_b  = din_arr[idx_b];
            end
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            clr_ptr_q   <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            port_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            port_sel_q  <= port_sel_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_ram_dp_bitmask_arbiter.sv
// Directed bench for ram_dp_bitmask_arbiter with a behavioural bit-masked
// dual-port RAM attached to the RAM pins.
module tb_ram_dp_bitmask_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             clear;
    logic             init_busy;
    logic [NR-1:0]    req_valid, req_ready, req_wen, rsp_valid;
    logic [NR*DW-1:0] req_bwen, req_din, rsp_rdata;
    logic [NR*AW-1:0] req_addr;
    logic             ram_cen, ram_wen_a, ram_wen_b;
    logic [DW-1:0]    ram_bwen_a, ram_bwen_b, ram_din_a, ram_din_b;
    logic [AW-1:0]    ram_addr_a, ram_addr_b;
    logic [DW-1:0]    ram_dout_a, ram_dout_b;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    ram_dp_bitmask_arbiter #(
        .DATA_WIDTH (DW),
        .DEPTH      (16),
        .NUM_REQ    (NR)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .init_busy  (init_busy),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_bwen   (req_bwen),
        .req_addr   (req_addr),
        .req_din    (req_din),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .ram_cen    (ram_cen),
        .ram_wen_a  (ram_wen_a),
        .ram_wen_b  (ram_wen_b),
        .ram_bwen_a (ram_bwen_a),
        .ram_bwen_b (ram_bwen_b),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_din_a  (ram_din_a),
        .ram_din_b  (ram_din_b),
        .ram_dout_a (ram_dout_a),
        .ram_dout_b (ram_dout_b)
    );

    // Behavioural RAM: bwen bit = 1 writes that bit; reads registered.
    logic [DW-1:0] mem [16];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | i;
        ram_dout_a = '0;
        ram_dout_b = '0;
    end

    always @(posedge clock) begin
        if (ram_cen) begin
            if (ram_wen_a)
                mem[ram_addr_a] <= (mem[ram_addr_a] & ~ram_bwen_a) | (ram_din_a & ram_bwen_a);
            else
                ram_dout_a <= mem[ram_addr_a];
            if (ram_wen_b)
                mem[ram_addr_b] <= (mem[ram_addr_b] & ~ram_bwen_b) | (ram_din_b & ram_bwen_b);
            else
                ram_dout_b <= mem[ram_addr_b];
        end
    end

    function automatic logic [DW-1:0] rdata(input int i);
        return rsp_rdata[i*DW +: DW];
    endfunction

    task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_valid[i]          = v;
        req_wen[i]            = w;
        req_addr[i*AW +: AW]  = a;
        req_din[i*DW +: DW]   = d;
        req_bwen[i*DW +: DW]  = m;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear = 1'b0;
        idle_all();
        set_req(0, 1'b1, 1'b0, 4'd0, '0, '0);
        set_req(1, 1'b1, 1'b0, 4'd15, '0, '0);
        repeat (2) @(negedge clock);
        #1;
        total++;
        if (init_busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", init_busy);
        else passed++;
        total++;
        if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid);
        else passed++;
        total++;
        if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready);
        else passed++;
        total++;
        if ({ram_addr_a, ram_addr_b} !== {4'd0, 4'd1})
            $display("FAIL reset_addr: got %0d,%0d want 0,1", ram_addr_a, ram_addr_b);
        else passed++;
    endtask

    task automatic test_sweep();
        logic [75:0] got, want;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            got  = {init_busy, req_ready, ram_cen, ram_wen_a, ram_wen_b, ram_addr_a, ram_addr_b,
                    ram_bwen_a, ram_bwen_b};
            want = {1'b1, 4'b0000, 3'b111, 4'(2*k), 4'(2*k+1), 32'hFFFF_FFFF, 32'hFFFF_FFFF};
            total++;
            if (got !== want || {ram_din_a, ram_din_b} !== 64'h0)
                $display("FAIL sweep_cycle%0d: got %h din %h want %h din 0", k, got,
                         {ram_din_a, ram_din_b}, want);
            else passed++;
            @(negedge clock);
        end
    endtask

    task automatic test_first_reads();
        #1;
        total++;
        if ({init_busy, req_ready} !== 5'b0_0011)
            $display("FAIL first_run_ready: got busy %b ready %b want 0 0011", init_busy, req_ready);
        else passed++;
        total++;
        if ({ram_cen, ram_wen_a, ram_wen_b, ram_addr_a, ram_addr_b} !== {3'b100, 4'd0, 4'd15})
            $display("FAIL first_run_pins: got cen%b wa%b wb%b a%0d b%0d want 1 0 0 0 15",
                     ram_cen, ram_wen_a, ram_wen_b, ram_addr_a, ram_addr_b);
        else passed++;
        @(negedge clock);
        idle_all();
        #1;
        total++;
        if (rsp_valid !== 4'b0011) $display("FAIL zero_rsp_valid: got %b want 0011", rsp_valid);
        else passed++;
        total++;
        if ({rdata(0), rdata(1)} !== 64'h0)
            $display("FAIL zero_rdata: got %h %h want 0 0", rdata(0), rdata(1));
        else passed++;
        @(negedge clock);
        #1;
        total++;
        if (rsp_valid !== 4'b0000) $display("FAIL zero_rsp_pulse: got %b want 0000", rsp_valid);
        else passed++;
    endtask

    task automatic test_masked_write();
        @(negedge clock);
        set_req(0, 1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 32'hFFFF_0000);
        #1;
        total++;
        if ({req_ready, ram_wen_a, ram_addr_a, ram_din_a, ram_bwen_a, ram_wen_b} !==
            {4'b0001, 1'b1, 4'd3, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b0})
            $display("FAIL mask_write_pins: got rdy%b wa%b a%0d d%h m%h wb%b", req_ready,
                     ram_wen_a, ram_addr_a, ram_din_a, ram_bwen_a, ram_wen_b);
        else passed++;
        @(negedge clock);
        set_req(0, 1'b1, 1'b0, 4'd3, '0, '0);
        #1;
        total++;
        if ({req_ready, ram_wen_a, ram_addr_a} !== {4'b0001, 1'b0, 4'd3})
            $display("FAIL mask_read_grant: got rdy%b wa%b a%0d want 0001 0 3",
                     req_ready, ram_wen_a, ram_addr_a);
        else passed++;
        @(negedge clock);
        idle_all();
        #1;
        total++;
        if (rsp_valid !== 4'b0001) $display("FAIL mask_rsp_valid: got %b want 0001", rsp_valid);
        else passed++;
        total++;
        if (rdata(0) !== 32'hDEAD_0000)
            $display("FAIL mask_rdata: got %h want dead0000", rdata(0));
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] prev, exp_rdy;
        @(negedge clock);
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 4'(8+i), 32'(32'h1111_1111*(i+1)), '1);
        #1;
        total++;
        if ({req_ready, ram_wen_a, ram_wen_b, ram_addr_a, ram_addr_b, ram_din_b} !==
            {4'b0110, 2'b11, 4'd9, 4'd10, 32'h3333_3333})
            $display("FAIL rr_write1: got rdy%b a%0d b%0d db%h want 0110 9 10 33333333",
                     req_ready, ram_addr_a, ram_addr_b, ram_din_b);
        else passed++;
        @(negedge clock);
        req_valid[1] = 1'b0;
        req_valid[2] = 1'b0;
        #1;
        total++;
        if ({req_ready, ram_addr_a, ram_addr_b} !== {4'b1001, 4'd11, 4'd8})
            $display("FAIL rr_write2: got rdy%b a%0d b%0d want 1001 11 8",
                     req_ready, ram_addr_a, ram_addr_b);
        else passed++;
        @(negedge clock);
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 4'(8+i), '0, '0);
        prev = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) idle_all();
            #1;
            exp_rdy = (c == 4) ? 4'b0000 : ((c % 2 == 0) ? 4'b0110 : 4'b1001);
            total++;
            if (req_ready !== exp_rdy)
                $display("FAIL rr_ready_c%0d: got %b want %b", c, req_ready, exp_rdy);
            else passed++;
            total++;
            if (rsp_valid !== prev)
                $display("FAIL rr_rsp_valid_c%0d: got %b want %b", c, rsp_valid, prev);
            else passed++;
            for (int i = 0; i < NR; i++) begin
                if (prev[i]) begin
                    total++;
                    if (rdata(i) !== 32'(32'h1111_1111*(i+1)))
                        $display("FAIL rr_rdata_c%0d_r%0d: got %h want %h", c, i, rdata(i),
                                 32'(32'h1111_1111*(i+1)));
                    else passed++;
                end
            end
            prev = exp_rdy;
            @(negedge clock);
        end
        #1;
        total++;
        if (rsp_valid !== 4'b0000) $display("FAIL rr_rsp_drain: got %b want 0000", rsp_valid);
        else passed++;
    endtask

    task automatic test_same_addr_write();
        @(negedge clock);
        set_req(1, 1'b1, 1'b1, 4'd5, 32'hAAAA_5555, '1);
        set_req(2, 1'b1, 1'b1, 4'd5, 32'h1234_5678, '1);
        #1;
        total++;
        if ({req_ready, ram_cen, ram_wen_b} !== {4'b0010, 2'b10})
            $display("FAIL waw_first: got rdy%b cen%b wb%b want 0010 1 0",
                     req_ready, ram_cen, ram_wen_b);
        else passed++;
        @(negedge clock);
        req_valid[1] = 1'b0;
        #1;
        total++;
        if ({req_ready, ram_addr_a, ram_din_a} !== {4'b0100, 4'd5, 32'h1234_5678})
            $display("FAIL waw_second: got rdy%b a%0d d%h want 0100 5 12345678",
                     req_ready, ram_addr_a, ram_din_a);
        else passed++;
        @(negedge clock);
        idle_all();
        set_req(3, 1'b1, 1'b0, 4'd5, '0, '0);
        #1;
        total++;
        if (req_ready !== 4'b1000) $display("FAIL waw_read_grant: got %b want 1000", req_ready);
        else passed++;
        @(negedge clock);
        idle_all();
        #1;
        total++;
        if ({rsp_valid, rdata(3)} !== {4'b1000, 32'h1234_5678})
            $display("FAIL waw_final: got v%b d%h want 1000 12345678", rsp_valid, rdata(3));
        else passed++;
    endtask

    task automatic test_same_addr_read();
        @(negedge clock);
        set_req(0, 1'b1, 1'b1, 4'd7, 32'hCAFE_F00D, '1);
        #1;
        total++;
        if (req_ready !== 4'b0001) $display("FAIL rar_setup: got %b want 0001", req_ready);
        else passed++;
        @(negedge clock);
        set_req(0, 1'b1, 1'b0, 4'd7, '0, '0);
        set_req(1, 1'b1, 1'b0, 4'd7, '0, '0);
        #1;
        total++;
        if ({req_ready, ram_wen_a, ram_wen_b, ram_addr_a, ram_addr_b} !== {4'b0011, 2'b00, 8'h77})
            $display("FAIL rar_grant: got rdy%b wa%b wb%b a%0d b%0d want 0011 0 0 7 7",
                     req_ready, ram_wen_a, ram_wen_b, ram_addr_a, ram_addr_b);
        else passed++;
        // Write from 0 and read from 1 to the same address: only one may go.
        @(negedge clock);
        set_req(0, 1'b1, 1'b1, 4'd7, 32'h0, '1);
        #1;
        total++;
        if ({rsp_valid, rdata(0), rdata(1)} !== {4'b0011, 32'hCAFE_F00D, 32'hCAFE_F00D})
            $display("FAIL rar_rsp: got v%b d0 %h d1 %h want 0011 cafef00d x2",
                     rsp_valid, rdata(0), rdata(1));
        else passed++;
        total++;
        if (req_ready !== 4'b0010) $display("FAIL rw_hazard_first: got %b want 0010", req_ready);
        else passed++;
        @(negedge clock);
        req_valid[1] = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, rdata(1)} !== {4'b0001, 4'b0010, 32'hCAFE_F00D})
            $display("FAIL rw_hazard_second: got rdy%b v%b d%h want 0001 0010 cafef00d",
                     req_ready, rsp_valid, rdata(1));
        else passed++;
        @(negedge clock);
        idle_all();
    endtask

    task automatic test_clear_inflight();
        @(negedge clock);
        set_req(2, 1'b1, 1'b0, 4'd5, '0, '0);
        #1;
        total++;
        if (req_ready !== 4'b0100) $display("FAIL clr_read_grant: got %b want 0100", req_ready);
        else passed++;
        @(negedge clock);
        idle_all();
        set_req(3, 1'b1, 1'b0, 4'd5, '0, '0);
        clear = 1'b1;
        #1;
        total++;
        if ({req_ready, ram_cen} !== 5'b0000_0)
            $display("FAIL clr_no_grant: got rdy%b cen%b want 0000 0", req_ready, ram_cen);
        else passed++;
        total++;
        if ({rsp_valid, rdata(2)} !== {4'b0100, 32'h1234_5678})
            $display("FAIL clr_inflight_rsp: got v%b d%h want 0100 12345678", rsp_valid, rdata(2));
        else passed++;
        @(negedge clock);
        clear = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            total++;
            if ({init_busy, req_ready, rsp_valid, ram_addr_a} !== {1'b1, 8'h00, 4'(2*k)})
                $display("FAIL clr_sweep_c%0d: got busy%b rdy%b v%b a%0d want 1 0000 0000 %0d",
                         k, init_busy, req_ready, rsp_valid, ram_addr_a, 2*k);
            else passed++;
            @(negedge clock);
        end
        #1;
        total++;
        if ({init_busy, req_ready} !== 5'b0_1000)
            $display("FAIL clr_done: got busy%b rdy%b want 0 1000", init_busy, req_ready);
        else passed++;
        @(negedge clock);
        idle_all();
        #1;
        total++;
        if ({rsp_valid, rdata(3)} !== {4'b1000, 32'h0})
            $display("FAIL clr_zeroed: got v%b d%h want 1000 0", rsp_valid, rdata(3));
        else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clock);
        set_req(0, 1'b1, 1'b0, 4'd0, '0, '0);
        #1;
        total++;
        if (req_ready !== 4'b0001) $display("FAIL rst_mid_grant: got %b want 0001", req_ready);
        else passed++;
        @(negedge clock);
        idle_all();
        reset = 1'b1;
        #1;
        total++;
        if ({rsp_valid, init_busy} !== 5'b0000_1)
            $display("FAIL rst_mid_drop: got v%b busy%b want 0000 1", rsp_valid, init_busy);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if ({ram_addr_a, ram_addr_b} !== {4'd0, 4'd1})
            $display("FAIL rst_mid_restart: got %0d,%0d want 0,1", ram_addr_a, ram_addr_b);
        else passed++;
        @(negedge clock);
        #1;
        total++;
        if (ram_addr_a !== 4'd2) $display("FAIL rst_mid_step: got %0d want 2", ram_addr_a);
        else passed++;
        n = 0;
        while (init_busy && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        total++;
        if (n !== 7) $display("FAIL rst_mid_sweep_len: got %0d more cycles want 7", n);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_first_reads();
        test_masked_write();
        test_round_robin();
        test_same_addr_write();
        test_same_addr_read();
        test_clear_inflight();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_dp_bitmask_arbiter.md
Name: ram_dp_bitmask_arbiter

Overview:
- Shares one dual-port bit-masked RAM (ports A/B, common `cen`, 1-cycle registered read) among NUM_REQ requesters.
- Grants up to two requests per cycle using round-robin with same-address hazard suppression.
- Returns read data to the requester that issued the read.
- Runs a clear sweep that zeroes every entry after reset and on request.
- Sits between client logic and the RAM macro; it is the only driver of the RAM pins.

Parameters:
- DATA_WIDTH, 32, RAM word width.
- DEPTH, 16, RAM entries.
- NUM_REQ, 4, number of requesters (at least 2).
- ADDR_WIDTH, $clog2(DEPTH), localparam.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  pulse; starts a clear sweep.
- init_busy  out  1  high while a clear sweep runs.
- req_valid  in  NUM_REQ  request valid per requester.
- req_ready  out  NUM_REQ  grant; transfer occurs when valid&ready.
- req_wen  in  NUM_REQ  1 = write, 0 = read.
- req_bwen  in  NUM_REQ*DATA_WIDTH  per-bit write mask; slice i belongs to requester i.
- req_addr  in  NUM_REQ*ADDR_WIDTH  address per requester.
- req_din  in  NUM_REQ*DATA_WIDTH  write data per requester.
- rsp_valid  out  NUM_REQ  read data valid, one-cycle pulse.
- rsp_rdata  out  NUM_REQ*DATA_WIDTH  read data; meaningful only with rsp_valid.
- ram_cen  out  1  RAM enable.
- ram_wen_a, ram_wen_b  out  1 each  RAM write enables.
- ram_bwen_a, ram_bwen_b  out  DATA_WIDTH each  RAM bit masks.
- ram_addr_a, ram_addr_b  out  ADDR_WIDTH each  RAM addresses.
- ram_din_a, ram_din_b  out  DATA_WIDTH each  RAM write data.
- ram_dout_a, ram_dout_b  in  DATA_WIDTH each  RAM registered read data.

Behaviour:
- States: INIT, RUN. Reset enters INIT with clr_ptr=0, rr_ptr=0, rsp_valid=0, init_busy=1, and all RAM-side outputs 0 except as driven by INIT.
- RAM-side outputs are combinational from state, pointers and requests.
- INIT:
  - ram_cen=1, both ports write with bwen all-ones and din=0.
  - Port A address = clr_ptr, port B address = clr_ptr+1.
  - clr_ptr increments by 2 each cycle.
  - If DEPTH is odd, on the last cycle port B has wen=0 (it performs a read, which is ignored).
  - Go to RUN after the cycle covering DEPTH-1. The sweep lasts ceil(DEPTH/2) cycles.
  - req_ready=0 throughout INIT.
- RUN, `clear` high: go to INIT next cycle with clr_ptr=0. No grants are issued in that cycle.
- `clear` during INIT restarts the sweep from 0.
- RUN arbitration (combinational, every cycle):
  - Port A: first valid requester searching from rr_ptr upward, with wrap.
  - Port B: next valid requester after A's, same wrap search, skipping any candidate whose address equals A's unless both are reads.
  - A requester receives at most one grant per cycle.
  - If nothing is eligible for B, port B is idle (wen_b=0).
- rr_ptr update: advances to (last granted index + 1) mod NUM_REQ. It is unchanged when there is no grant.
- ram_cen = 1 when any grant exists, 0 otherwise. An idle port while cen=1 reads; its data is discarded.
- Writes: din, bwen and addr are passed straight through. The write completes at the clock edge of the grant.
- Reads:
  - rsp_valid[i] pulses exactly one cycle after requester i's read grant.
  - rsp_rdata slice i = ram_dout of the port used, selected through a registered port-select.
  - Latency from grant to rsp_valid is 1 cycle.
- Read-after-write to the same address in consecutive cycles returns the new data. Same-cycle RAW is impossible because of hazard suppression.
- Clear while a read is in flight: that response is still delivered in the next cycle.
- Reset mid-operation: rsp_valid is dropped immediately, and the sweep restarts from 0 once reset is released.
- Requester contract: hold request fields stable while valid is high and ready is low.

Decomposition:
- Package ram_arb_pkg:
  - State enum {ST_INIT, ST_RUN}.
  - Port-select constants PORT_A=0, PORT_B=1.
- Sub-module rr_pick:
  - Inputs: NUM_REQ-bit eligible mask and start pointer.
  - Outputs: one-hot grant, found flag and index.
  - Instantiated twice: the A pick, then the B pick over a mask with A's grant and conflicting requesters removed.

Test Plan:
- Release reset, DEPTH=16 → init_busy high for 8 cycles. Addr pairs (0,1)…(14,15) are written with 0. All subsequent reads return 0.
- Req0 writes addr 3 with din 0xDEADBEEF and bwen 0xFFFF0000, then reads addr 3 → rsp_valid[0] one cycle after grant, rsp_rdata0 = 0xDEAD0000.
- All 4 requesters hold reads to distinct addresses continuously → grants (0,1), then (2,3), alternating. Each rsp_valid pulses exactly once per accepted read.
- Req1 and req2 both write addr 5, other requesters idle → only one is granted per cycle; both complete in 2 cycles. Final content equals the later-granted write.
- Req0 and req1 read the same addr 7 → both granted in the same cycle, and both responses match the same data.
- Assert clear while req2's read is in flight → req2's response is still delivered. init_busy=1 for 8 cycles, and no req_ready is asserted until the sweep ends.
